// File: rtl/cp0_ctrl_if.sv
// rtl/cp0_ctrl_if.sv - MEM-stage CP0 bundle between the pipeline and cp0_ctrl
interface cp0_ctrl_if;
  logic [2:0]  mem_cp0op;
  logic [4:0]  mem_cs;
  logic [2:0]  mem_sel;
  logic [31:0] mem_busB_mux2;
  logic [31:0] mem_pc;
  logic [5:0]  hw_int;
  logic [31:0] cp0_dout;
  logic [1:0]  cp0bubble;
  logic        cp0_redirect;
  logic [31:0] cp0_target;

  // Pipeline side drives the EX/MEM CP0 fields and consumes the redirect/flush controls
  modport master (
    output mem_cp0op, mem_cs, mem_sel, mem_busB_mux2, mem_pc, hw_int,
    input  cp0_dout, cp0bubble, cp0_redirect, cp0_target
  );

  // CP0 side
  modport slave (
    input  mem_cp0op, mem_cs, mem_sel, mem_busB_mux2, mem_pc, hw_int,
    output cp0_dout, cp0bubble, cp0_redirect, cp0_target
  );
endinterface

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - MEM-stage coprocessor-0 controller (optional timer: CP0_TIMER_EN)
module cp0_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0380,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input logic       clk,
  input logic       rst,
  cp0_ctrl_if.slave bus
);
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;
  localparam logic [2:0] OP_BREAK   = 3'b101;

  typedef enum logic {NORMAL, FLUSH} state_t;

  state_t      state, next_state;
  logic [2:0]  flush_cnt, next_flush_cnt;

  logic        ie, exl;
  logic [7:0]  im;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic        redirect_q;
  logic [31:0] target_q;
  logic        timer_flag;
  logic [7:0]  ip;

  logic        take_int, take_exc, take_eret, do_mtc0, wr_en;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
`endif

  // Pending interrupt vector; the timer shares the IP7 line with hw_int[5]
  assign ip    = {ip_hw[5] | timer_flag, ip_hw[4:0], ip_sw};
  assign wr_en = do_mtc0 && (bus.mem_sel == 3'd0);

  assign bus.cp0_redirect = redirect_q;
  assign bus.cp0_target   = target_q;

  // MFC0 read mux, independent of the operation in MEM
  always_comb begin
    bus.cp0_dout = '0;
    if (bus.mem_sel == 3'd0) begin
      case (bus.mem_cs)
`ifdef CP0_TIMER_EN
        5'd9:    bus.cp0_dout = count;
        5'd11:   bus.cp0_dout = compare;
`endif
        5'd12:   bus.cp0_dout = {16'd0, im, 6'd0, exl, ie};
        5'd13:   bus.cp0_dout = {16'd0, ip, 1'b0, exc_code, 2'b00};
        5'd14:   bus.cp0_dout = epc;
        default: bus.cp0_dout = '0;
      endcase
    end
  end

  // State register and flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NORMAL;
      flush_cnt <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
    end
  end

  // Next-state, priority decode of the MEM op and the flush code
  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    bus.cp0bubble  = 2'd0;
    take_int       = 1'b0;
    take_exc       = 1'b0;
    take_eret      = 1'b0;
    do_mtc0        = 1'b0;
    if (state == NORMAL) begin
      if (ie && !exl && ((ip & im) != 8'd0)) begin
        take_int = 1'b1;
        // kill the cp0op sitting in EX/MEM so it cannot retire behind the exception
        if (bus.mem_cp0op != 3'd0) bus.cp0bubble = 2'd2;
      end else if (bus.mem_cp0op == OP_SYSCALL || bus.mem_cp0op == OP_BREAK) begin
        take_exc = 1'b1;
      end else if (bus.mem_cp0op == OP_ERET) begin
        take_eret = 1'b1;
      end else if (bus.mem_cp0op == OP_MTC0) begin
        do_mtc0 = 1'b1;
      end
      if (take_int || take_exc || take_eret) begin
        next_state     = FLUSH;
        next_flush_cnt = 3'(FLUSH_CYCLES - 1);
      end
    end else begin
      bus.cp0bubble = 2'd1;
      if (flush_cnt == 3'd0) next_state = NORMAL;
      else                   next_flush_cnt = flush_cnt - 3'd1;
    end
  end

  // Status/Cause/EPC updates, redirect pulse and target capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie         <= 1'b0;
      exl        <= 1'b0;
      im         <= '0;
      ip_hw      <= '0;
      ip_sw      <= '0;
      exc_code   <= '0;
      epc        <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      ip_hw      <= bus.hw_int;
      redirect_q <= take_int || take_exc || take_eret;
      if (take_int) begin
        epc      <= bus.mem_pc;
        exc_code <= 5'd0;
        exl      <= 1'b1;
        target_q <= HANDLER_ADDR;
      end
      if (take_exc) begin
        // nested exception keeps the original return address
        if (!exl) epc <= bus.mem_pc + 32'd4;
        exc_code <= (bus.mem_cp0op == OP_BREAK) ? 5'd9 : 5'd8;
        exl      <= 1'b1;
        target_q <= HANDLER_ADDR;
      end
      if (take_eret) begin
        exl      <= 1'b0;
        target_q <= epc;
      end
      if (wr_en) begin
        case (bus.mem_cs)
          5'd12: begin
            im  <= bus.mem_busB_mux2[15:8];
            exl <= bus.mem_busB_mux2[1];
            ie  <= bus.mem_busB_mux2[0];
          end
          5'd13:   ip_sw <= bus.mem_busB_mux2[9:8];
          5'd14:   epc   <= bus.mem_busB_mux2;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  // Free-running Count, Compare and the sticky timer match flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      compare    <= '0;
      timer_flag <= 1'b0;
    end else begin
      if (wr_en && bus.mem_cs == 5'd9) count <= bus.mem_busB_mux2;
      else                             count <= count + 32'd1;
      if (wr_en && bus.mem_cs == 5'd11) begin
        compare    <= bus.mem_busB_mux2;
        timer_flag <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        timer_flag <= 1'b1;
      end
    end
  end
`else
  assign timer_flag = 1'b0;
`endif
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - self-checking bench for cp0_ctrl against a behavioural CP0 model
module tb_cp0_ctrl;
  localparam logic [31:0] HANDLER = 32'h0000_0380;
  localparam int FLUSH_N = 3;
  localparam logic [2:0] OP_NONE = 3'd0, OP_MFC0 = 3'd1, OP_MTC0 = 3'd2;
  localparam logic [2:0] OP_SYSCALL = 3'd3, OP_ERET = 3'd4, OP_BREAK = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_ctrl_if bus();
  cp0_ctrl #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FLUSH_N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_ie, m_exl, m_flag, m_redir;
  logic [7:0]  m_im;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_count, m_compare, m_target;
  int          m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_flag = 0; m_redir = 0; m_im = 0; m_iphw = 0; m_ipsw = 0;
    m_exc = 0; m_epc = 0; m_count = 0; m_compare = 0; m_target = 0; m_flush = 0;
  endtask

  function automatic logic [7:0] m_ip();
    return {m_iphw[5] | m_flag, m_iphw[4:0], m_ipsw};
  endfunction

  function automatic bit m_intr();
    return (m_flush == 0) && m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] cs, input logic [2:0] sel);
    if (sel != 3'd0) return 32'd0;
    case (cs)
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      5'd12: return {16'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13: return {16'd0, m_ip(), 1'b0, m_exc, 2'b00};
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_bubble(input logic [2:0] op);
    if (m_flush > 0) return 2'd1;
    if (m_intr() && op != 3'd0) return 2'd2;
    return 2'd0;
  endfunction

  // Applies one clock edge of architectural behaviour to the model
  task automatic model_edge(input logic [2:0] op, input logic [4:0] cs, input logic [2:0] sel,
                            input logic [31:0] d, input logic [31:0] pc, input logic [5:0] hw);
    bit busy, intr, wr, old_exl;
    logic [31:0] old_epc;
    busy = (m_flush > 0);
    intr = m_intr();
    wr = !busy && !intr && op == OP_MTC0 && sel == 3'd0;
    old_epc = m_epc;
    old_exl = m_exl;
    m_redir = 0;
    if (busy) m_flush--;
    else if (intr) begin
      m_epc = pc; m_exc = 5'd0; m_exl = 1;
      m_flush = FLUSH_N; m_redir = 1; m_target = HANDLER;
    end else if (op == OP_SYSCALL || op == OP_BREAK) begin
      if (!old_exl) m_epc = pc + 32'd4;
      m_exc = (op == OP_SYSCALL) ? 5'd8 : 5'd9; m_exl = 1;
      m_flush = FLUSH_N; m_redir = 1; m_target = HANDLER;
    end else if (op == OP_ERET) begin
      m_exl = 0;
      m_flush = FLUSH_N; m_redir = 1; m_target = old_epc;
    end
`ifdef CP0_TIMER_EN
    if (wr && cs == 5'd11) m_flag = 0;
    else if (m_count == m_compare && m_compare != 0) m_flag = 1;
    if (wr && cs == 5'd9) m_count = d; else m_count = m_count + 32'd1;
    if (wr && cs == 5'd11) m_compare = d;
`endif
    if (wr) begin
      case (cs)
        5'd12: begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
        5'd13: m_ipsw = d[9:8];
        5'd14: m_epc = d;
        default: ;
      endcase
    end
    m_iphw = hw;
  endtask

  // One pipeline cycle: drive, check combinational and registered outputs, advance
  task automatic cyc(input string tag, input logic [2:0] op, input logic [4:0] cs, input logic [2:0] sel,
                     input logic [31:0] d, input logic [31:0] pc, input logic [5:0] hw);
    bus.mem_cp0op = op; bus.mem_cs = cs; bus.mem_sel = sel;
    bus.mem_busB_mux2 = d; bus.mem_pc = pc; bus.hw_int = hw;
    #1;
    check({tag, ":dout"}, bus.cp0_dout, exp_read(cs, sel));
    check({tag, ":bubble"}, 32'(bus.cp0bubble), 32'(exp_bubble(op)));
    check({tag, ":redirect"}, 32'(bus.cp0_redirect), 32'(m_redir));
    check({tag, ":target"}, bus.cp0_target, m_target);
    model_edge(op, cs, sel, d, pc, hw);
    @(posedge clk);
    #1;
  endtask

  // Simple read-only cycle
  task automatic rd(input string tag, input logic [4:0] cs, input logic [5:0] hw);
    cyc(tag, OP_MFC0, cs, 3'd0, 32'd0, 32'h0000_0040, hw);
  endtask

  initial begin
    logic [4:0] cs_tab [6];
    bit seen;
    cs_tab[0] = 5'd9; cs_tab[1] = 5'd11; cs_tab[2] = 5'd12;
    cs_tab[3] = 5'd13; cs_tab[4] = 5'd14; cs_tab[5] = 5'd3;

    bus.mem_cp0op = OP_NONE; bus.mem_cs = 5'd12; bus.mem_sel = 3'd0;
    bus.mem_busB_mux2 = 32'd0; bus.mem_pc = 32'd0; bus.hw_int = 6'd0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst:bubble", 32'(bus.cp0bubble), 32'd0);
    check("rst:redirect", 32'(bus.cp0_redirect), 32'd0);
    check("rst:target", bus.cp0_target, 32'd0);
    check("rst:status", bus.cp0_dout, 32'd0);
    bus.mem_cs = 5'd14; #1;
    check("rst:epc", bus.cp0_dout, 32'd0);
    rst = 1'b0;

    // register access and sel gating
    cyc("mtc0_status", OP_MTC0, 5'd12, 3'd0, 32'h0000_FF01, 32'h0000_0010, 6'd0);
    rd("mfc0_status", 5'd12, 6'd0);
    cyc("mfc0_status_sel1", OP_MFC0, 5'd12, 3'd1, 32'd0, 32'h0000_0014, 6'd0);
    cyc("mtc0_sel1_ignored", OP_MTC0, 5'd14, 3'd2, 32'hDEAD_BEEF, 32'h0000_0018, 6'd0);
    rd("mfc0_epc", 5'd14, 6'd0);
    cyc("mtc0_count", OP_MTC0, 5'd9, 3'd0, 32'h0000_1234, 32'h0000_001C, 6'd0);
    rd("mfc0_count", 5'd9, 6'd0);
    cyc("mtc0_unmapped", OP_MTC0, 5'd3, 3'd0, 32'h1111_2222, 32'h0000_0020, 6'd0);

    // SYSCALL entry, flush window, then ERET back
    cyc("syscall", OP_SYSCALL, 5'd12, 3'd0, 32'd0, 32'h0000_0100, 6'd0);
    rd("sys_f1_epc", 5'd14, 6'd0);
    rd("sys_f2_cause", 5'd13, 6'd0);
    rd("sys_f3_status", 5'd12, 6'd0);
    cyc("sys_after", OP_NONE, 5'd14, 3'd0, 32'd0, 32'h0000_0104, 6'd0);
    cyc("eret", OP_ERET, 5'd12, 3'd0, 32'd0, 32'h0000_0384, 6'd0);
    rd("eret_f1", 5'd12, 6'd0);
    rd("eret_f2", 5'd12, 6'd0);
    rd("eret_f3", 5'd12, 6'd0);
    rd("eret_after", 5'd12, 6'd0);

    // external interrupt suppresses an MTC0 in MEM
    cyc("int_status", OP_MTC0, 5'd12, 3'd0, 32'h0000_0401, 32'h0000_01F8, 6'd0);
    cyc("int_raise", OP_NONE, 5'd12, 3'd0, 32'd0, 32'h0000_01FC, 6'd1);
    cyc("int_take", OP_MTC0, 5'd14, 3'd0, 32'hCAFE_0000, 32'h0000_0200, 6'd1);
    rd("int_f1_epc", 5'd14, 6'd1);
    rd("int_f2_cause", 5'd13, 6'd1);
    rd("int_f3_status", 5'd12, 6'd0);
    cyc("int_eret", OP_ERET, 5'd13, 3'd0, 32'd0, 32'h0000_0390, 6'd0);
    rd("int_eret_f1", 5'd13, 6'd0);
    rd("int_eret_f2", 5'd13, 6'd0);
    rd("int_eret_f3", 5'd13, 6'd0);
    cyc("clr_status", OP_MTC0, 5'd12, 3'd0, 32'd0, 32'h0000_0204, 6'd0);

`ifdef CP0_TIMER_EN
    // timer interrupt at Count == Compare
    cyc("tmr_cmp", OP_MTC0, 5'd11, 3'd0, 32'd10, 32'h0000_0300, 6'd0);
    cyc("tmr_cnt", OP_MTC0, 5'd9, 3'd0, 32'd0, 32'h0000_0304, 6'd0);
    cyc("tmr_status", OP_MTC0, 5'd12, 3'd0, 32'h0000_8001, 32'h0000_0308, 6'd0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc("tmr_wait", OP_NONE, 5'd9, 3'd0, 32'd0, 32'h0000_0400 + 32'(i * 4), 6'd0);
      seen = bus.cp0_redirect;
    end
    check("tmr_fired", 32'(seen), 32'd1);
    rd("tmr_f_cause", 5'd13, 6'd0);
    rd("tmr_f_epc", 5'd14, 6'd0);
    rd("tmr_f_count", 5'd9, 6'd0);
    cyc("tmr_clear", OP_MTC0, 5'd11, 3'd0, 32'd10, 32'h0000_0500, 6'd0);
    rd("tmr_ip7_clr", 5'd13, 6'd0);
    cyc("tmr_eret", OP_ERET, 5'd13, 3'd0, 32'd0, 32'h0000_0504, 6'd0);
    rd("tmr_eret_f1", 5'd13, 6'd0);
    rd("tmr_eret_f2", 5'd13, 6'd0);
    rd("tmr_eret_f3", 5'd13, 6'd0);
    cyc("tmr_off", OP_MTC0, 5'd12, 3'd0, 32'd0, 32'h0000_0508, 6'd0);
`endif

    // randomized mix of register traffic and traps; IE kept clear
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [4:0] cs;
      logic [2:0] sel, op;
      logic [31:0] d;
      r = int'($urandom_range(0, 9));
      cs = cs_tab[$urandom_range(0, 5)];
      sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      d = $urandom;
      if (cs == 5'd12) d[0] = 1'b0;
      if (r <= 3) op = OP_MTC0;
      else if (r <= 6) op = OP_MFC0;
      else if (r == 7) op = OP_NONE;
      else if (r == 8) op = (i % 2 == 0) ? OP_SYSCALL : OP_BREAK;
      else op = OP_ERET;
      cyc("rand", op, cs, sel, d, $urandom & 32'hFFFF_FFFC, 6'd0);
    end
    for (int i = 0; i < FLUSH_N; i++) rd("rand_drain", 5'd13, 6'd0);

    // reset in the second flush cycle
    cyc("rflush_status", OP_MTC0, 5'd12, 3'd0, 32'h0000_0303, 32'h0000_0600, 6'd0);
    cyc("rflush_sys", OP_SYSCALL, 5'd12, 3'd0, 32'd0, 32'h0000_0604, 6'd0);
    rd("rflush_f1", 5'd12, 6'd0);
    bus.mem_cp0op = OP_NONE; bus.mem_cs = 5'd12; bus.mem_sel = 3'd0;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("rflush:bubble", 32'(bus.cp0bubble), 32'd0);
    check("rflush:redirect", 32'(bus.cp0_redirect), 32'd0);
    check("rflush:status", bus.cp0_dout, 32'd0);
    bus.mem_cs = 5'd14; #1;
    check("rflush:epc", bus.cp0_dout, 32'd0);
    check("rflush:target", bus.cp0_target, 32'd0);
    rst = 1'b0;
    model_edge(OP_NONE, 5'd14, 3'd0, 32'd0, 32'd0, 6'd0);
    @(posedge clk);
    #1;
    cyc("post_rst_mtc0", OP_MTC0, 5'd14, 3'd0, 32'h0000_0055, 32'h0000_0700, 6'd0);
    rd("post_rst_mfc0", 5'd14, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 controller at the MEM stage; consumes the CP0 fields carried by the EX/MEM pipeline register (cp0op, cs, sel, busB_mux2) plus the MEM-stage PC.
- Services MFC0/MTC0, takes SYSCALL/BREAK/interrupt exceptions, executes ERET.
- Drives PC redirect and the cp0bubble flush code back into the pipeline registers.
- Holds Status, Cause, EPC, Count, Compare.

Parameters:
HANDLER_ADDR, 32'h0000_0380, exception vector loaded on exception entry
FLUSH_CYCLES, 3, cycles cp0bubble=1 is held after a redirect (1..7)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
mem_cp0op  in  3  000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET, 101 BREAK, others = none
mem_cs  in  5  CP0 register number
mem_sel  in  3  CP0 select field
mem_busB_mux2  in  32  MTC0 write data
mem_pc  in  32  PC of instruction in MEM
hw_int  in  6  external interrupt lines, level sensitive
cp0_dout  out  32  MFC0 read data, combinational
cp0bubble  out  2  0 normal, 1 flush IF..MEM, 2 kill in-flight cp0op in EX/MEM
cp0_redirect  out  1  one-cycle pulse: fetch from cp0_target
cp0_target  out  32  redirect address

Behaviour:
- Reset (async, rst=1): Status=0, Cause=0, EPC=0, Count=0, Compare=0, state=NORMAL, flush counter=0, cp0bubble=0, cp0_redirect=0, cp0_target=0.
- Register map, sel must be 0; otherwise reads return 0 and writes are ignored:
  - cs9 Count.
  - cs11 Compare.
  - cs12 Status: bit0 IE, bit1 EXL, bits15:8 IM, other bits read 0.
  - cs13 Cause: bits15:8 IP, bits6:2 ExcCode; only IP1:0 writable.
  - cs14 EPC.
  - Unmapped cs reads 0, writes ignored.
- cp0_dout = selected register, combinational on mem_cs/mem_sel regardless of op.
- IP[7:2] registered each cycle from hw_int[5:0]; IP7 additionally ORed with the timer flag.
- int_take = NORMAL & IE & !EXL & |(IP & IM).
- FSM NORMAL, evaluated each posedge in priority order:
  1. int_take:
     - EPC<=mem_pc; ExcCode<=0; EXL<=1.
     - Any mem_cp0op this cycle is suppressed (no MTC0 write).
     - cp0bubble=2 combinationally this cycle if mem_cp0op!=0.
     - -> FLUSH.
  2. SYSCALL/BREAK:
     - EPC<=mem_pc+4; ExcCode<=8/9; EXL<=1.
     - -> FLUSH with target HANDLER_ADDR.
  3. ERET:
     - EXL<=0.
     - -> FLUSH with target=EPC (pre-update value).
  4. MTC0: write register at posedge; no state change.
- Exception entry (1, 2) sets target=HANDLER_ADDR.
- Entering FLUSH: cp0_redirect=1 for exactly the first FLUSH cycle; cp0_target registered with it.
- FLUSH state:
  - cp0bubble=1 for FLUSH_CYCLES cycles.
  - mem_cp0op ignored; interrupts not taken.
  - Then -> NORMAL with cp0bubble=0.
- Latency: exception detected at edge N -> redirect high during cycle N+1.
- Count: +1 every clk, wraps 0xFFFF_FFFF->0.
- Timer: flag set when Count==Compare and Compare!=0; cleared by any MTC0 to Compare.
- Same-cycle MTC0 and counter update: the MTC0 value wins (Count written, not incremented).
- ERET while EXL=0: still redirects to EPC.
- Exception while EXL=1: EPC not updated, ExcCode still updated.
- rst asserted in FLUSH: immediate return to NORMAL with all outputs 0.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count/Compare and the timer flag as above.
- Undefined:
  - cs9/cs11 read 0, writes ignored.
  - No counter logic.
  - IP7 = hw_int[5] only.

Test Plan:
- MTC0 cs12 data 0x0000_FF01, then MFC0 cs12 -> cp0_dout=0x0000_FF01. MFC0 cs12 sel=1 -> 0.
- SYSCALL with mem_pc=0x100:
  - next cycle: cp0_redirect=1, cp0_target=0x380.
  - cp0bubble=1 for 3 cycles, then 0.
  - EPC=0x104, Cause[6:2]=8, Status.EXL=1.
- Then ERET -> cp0_redirect=1, cp0_target=0x104, EXL=0, cp0bubble=1 for 3 cycles.
- Status=0x0000_0401, hw_int[0]=1 while mem_cp0op=MTC0 to cs14 at mem_pc=0x200:
  - cp0bubble=2 that cycle.
  - EPC=0x200 (MTC0 suppressed), ExcCode=0, redirect to 0x380.
- CP0_TIMER_EN, Compare=10, Count=0, Status=0x0000_8001 -> interrupt taken when Count reaches 10. MTC0 Compare clears IP7.
- rst pulsed mid-FLUSH (2nd cycle) -> cp0bubble, cp0_redirect, Status, EPC all 0 immediately; normal MTC0 accepted next cycle.
